// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared constants, types and helpers for the frame configuration sequencer
package frame_cfg_pkg;

  localparam int NUM_CH       = 3;
  localparam int LOAD_IMM_BIT = 7;

  localparam logic [15:0] DEF_MAX_WIDTH = 16'd1920;

  // Commit sequencer states, kept as plain constants for legacy tooling
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_LD_MODE = 3'd2;
  localparam logic [2:0] ST_LD_CH0  = 3'd3;
  localparam logic [2:0] ST_LD_CH1  = 3'd4;
  localparam logic [2:0] ST_LD_CH2  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // One channel's worth of crop/scale configuration
  typedef struct packed {
    logic [7:0]  hsync;
    logic [15:0] vsync;
    logic [15:0] width;
  } ch_cfg_t;

  // A zero width would stall the scaler and anything above the line buffer overflows it
  function automatic logic width_ok(input logic [15:0] w, input logic [15:0] max_w);
    return (w != 16'd0) && (w <= max_w);
  endfunction

endpackage

// File: rtl/cfg_ch_shadow.sv
// rtl/cfg_ch_shadow.sv - active configuration register set for one scaler/crop channel
module cfg_ch_shadow
  import frame_cfg_pkg::*;
#(
  parameter logic [15:0] MAX_WIDTH = DEF_MAX_WIDTH
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    load_i,
  input  logic    clr_err_i,
  input  ch_cfg_t stage_i,
  output ch_cfg_t act_o,
  output logic    pulse_o,
  output logic    err_o
);

  ch_cfg_t act_d, act_q;
  logic    pulse_d, pulse_q;
  logic    err_d, err_q;

  // Accept the staged set only when its width is legal; otherwise flag it and keep the old set
  always_comb begin
    act_d   = act_q;
    pulse_d = 1'b0;
    err_d   = err_q;
    if (clr_err_i) begin
      err_d = 1'b0;
    end
    if (load_i) begin
      if (width_ok(stage_i.width, MAX_WIDTH)) begin
        act_d   = stage_i;
        pulse_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Active set, load pulse and error flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      act_q   <= act_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign act_o   = act_q;
  assign pulse_o = pulse_q;
  assign err_o   = err_q;

endmodule

// File: rtl/frame_cfg_sequencer.sv
// rtl/frame_cfg_sequencer.sv - frame-synchronous atomic commit of staged SPI0 channel configuration
module frame_cfg_sequencer
  import frame_cfg_pkg::*;
#(
  parameter logic        VS_POL    = 1'b1,
  parameter logic [15:0] MAX_WIDTH = DEF_MAX_WIDTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        vsync_i,
  input  logic [7:0]  img_mode_i,
  input  logic [7:0]  base_hsync_ch0_i,
  input  logic [7:0]  base_hsync_ch1_i,
  input  logic [7:0]  base_hsync_ch2_i,
  input  logic [15:0] base_vsync_ch0_i,
  input  logic [15:0] base_vsync_ch1_i,
  input  logic [15:0] base_vsync_ch2_i,
  input  logic [15:0] width_ch0_i,
  input  logic [15:0] width_ch1_i,
  input  logic [15:0] width_ch2_i,
  input  logic [7:0]  chx_load_en_i,
  output logic [7:0]  act_img_mode_o,
  output logic [7:0]  act_base_hsync_ch0_o,
  output logic [7:0]  act_base_hsync_ch1_o,
  output logic [7:0]  act_base_hsync_ch2_o,
  output logic [15:0] act_base_vsync_ch0_o,
  output logic [15:0] act_base_vsync_ch1_o,
  output logic [15:0] act_base_vsync_ch2_o,
  output logic [15:0] act_width_ch0_o,
  output logic [15:0] act_width_ch1_o,
  output logic [15:0] act_width_ch2_o,
  output logic [2:0]  ch_load_pulse_o,
  output logic        commit_done_o,
  output logic        pending_o,
  output logic        busy_o,
  output logic [2:0]  err_width_o,
  output logic [7:0]  commit_cnt_o
);

  logic        vs_d0_d, vs_d0_q;
  logic        vs_d1_d, vs_d1_q;
  logic [2:0]  ld_prev_d, ld_prev_q;
  logic [2:0]  state_d, state_q;
  logic [2:0]  req_mask_d, req_mask_q;
  logic        imm_d, imm_q;
  logic        pend_next_d, pend_next_q;
  logic [2:0]  next_mask_d, next_mask_q;
  logic        next_imm_d, next_imm_q;
  logic [7:0]  mode_d, mode_q;
  logic [7:0]  cnt_d, cnt_q;

  logic        vs_norm;
  logic        vs_rise;
  logic [2:0]  ld_mask;
  logic        arm;
  logic        imm;
  logic        in_commit;
  logic        clr_err;
  logic [NUM_CH-1:0] ld_strobe;
  logic [NUM_CH-1:0] ch_pulse;
  logic [NUM_CH-1:0] ch_err;
  logic        ld_unused;

  ch_cfg_t stage_cfg [NUM_CH];
  ch_cfg_t act_cfg   [NUM_CH];

  assign vs_norm   = (vsync_i == VS_POL);
  assign vs_rise   = vs_d0_q & ~vs_d1_q;
  assign ld_mask   = chx_load_en_i[2:0];
  assign arm       = (ld_mask != ld_prev_q) && (ld_mask != 3'b000);
  assign imm       = chx_load_en_i[LOAD_IMM_BIT];
  assign ld_unused = ^chx_load_en_i[6:3];

  // LD_MODE through LD_CH2: an arm here is deferred to the next commit
  assign in_commit = (state_q == ST_LD_MODE) || (state_q == ST_LD_CH0) ||
                     (state_q == ST_LD_CH1)  || (state_q == ST_LD_CH2);
  assign clr_err   = (state_q == ST_LD_MODE);

  // Sync history, arm bookkeeping and the commit sequence
  always_comb begin
    vs_d0_d     = vs_norm;
    vs_d1_d     = vs_d0_q;
    ld_prev_d   = ld_mask;
    state_d     = state_q;
    req_mask_d  = req_mask_q;
    imm_d       = imm_q;
    pend_next_d = pend_next_q;
    next_mask_d = next_mask_q;
    next_imm_d  = next_imm_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;

    if (arm && in_commit) begin
      pend_next_d = 1'b1;
      next_mask_d = next_mask_q | ld_mask;
      next_imm_d  = next_imm_q | imm;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          req_mask_d = ld_mask;
          imm_d      = imm;
          state_d    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (arm) begin
          req_mask_d = req_mask_q | ld_mask;
          imm_d      = imm_q | imm;
        end
        if (vs_rise || imm_q) begin
          state_d = ST_LD_MODE;
        end
      end
      ST_LD_MODE: begin
        mode_d  = img_mode_i;
        state_d = ST_LD_CH0;
      end
      ST_LD_CH0: state_d = ST_LD_CH1;
      ST_LD_CH1: state_d = ST_LD_CH2;
      ST_LD_CH2: state_d = ST_DONE;
      ST_DONE: begin
        cnt_d       = cnt_q + 8'd1;
        req_mask_d  = 3'b000;
        imm_d       = 1'b0;
        pend_next_d = 1'b0;
        next_mask_d = 3'b000;
        next_imm_d  = 1'b0;
        // An arm landing in DONE itself still belongs to the next commit
        if (pend_next_q || arm) begin
          req_mask_d = next_mask_q | (arm ? ld_mask : 3'b000);
          imm_d      = next_imm_q | (arm & imm);
          state_d    = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset drops any commit in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d0_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      ld_prev_q   <= 3'b000;
      state_q     <= ST_IDLE;
      req_mask_q  <= 3'b000;
      imm_q       <= 1'b0;
      pend_next_q <= 1'b0;
      next_mask_q <= 3'b000;
      next_imm_q  <= 1'b0;
      mode_q      <= 8'd0;
      cnt_q       <= 8'd0;
    end else begin
      vs_d0_q     <= vs_d0_d;
      vs_d1_q     <= vs_d1_d;
      ld_prev_q   <= ld_prev_d;
      state_q     <= state_d;
      req_mask_q  <= req_mask_d;
      imm_q       <= imm_d;
      pend_next_q <= pend_next_d;
      next_mask_q <= next_mask_d;
      next_imm_q  <= next_imm_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
    end
  end

  // Each channel gets its strobe only in its own LD_CH slot and only if requested
  always_comb begin
    ld_strobe = '0;
    case (state_q)
      ST_LD_CH0: ld_strobe[0] = req_mask_q[0];
      ST_LD_CH1: ld_strobe[1] = req_mask_q[1];
      ST_LD_CH2: ld_strobe[2] = req_mask_q[2];
      default:   ld_strobe = '0;
    endcase
  end

  assign stage_cfg[0] = {base_hsync_ch0_i, base_vsync_ch0_i, width_ch0_i};
  assign stage_cfg[1] = {base_hsync_ch1_i, base_vsync_ch1_i, width_ch1_i};
  assign stage_cfg[2] = {base_hsync_ch2_i, base_vsync_ch2_i, width_ch2_i};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    cfg_ch_shadow #(
      .MAX_WIDTH(MAX_WIDTH)
    ) u_shadow (
      .clock     (clock),
      .reset_n   (reset_n),
      .load_i    (ld_strobe[n]),
      .clr_err_i (clr_err),
      .stage_i   (stage_cfg[n]),
      .act_o     (act_cfg[n]),
      .pulse_o   (ch_pulse[n]),
      .err_o     (ch_err[n])
    );
  end

  assign act_img_mode_o       = mode_q;
  assign act_base_hsync_ch0_o = act_cfg[0].hsync;
  assign act_base_hsync_ch1_o = act_cfg[1].hsync;
  assign act_base_hsync_ch2_o = act_cfg[2].hsync;
  assign act_base_vsync_ch0_o = act_cfg[0].vsync;
  assign act_base_vsync_ch1_o = act_cfg[1].vsync;
  assign act_base_vsync_ch2_o = act_cfg[2].vsync;
  assign act_width_ch0_o      = act_cfg[0].width;
  assign act_width_ch1_o      = act_cfg[1].width;
  assign act_width_ch2_o      = act_cfg[2].width;
  assign ch_load_pulse_o      = ch_pulse;
  assign err_width_o          = ch_err;
  assign commit_done_o        = (state_q == ST_DONE);
  assign pending_o            = (state_q == ST_ARMED);
  assign busy_o               = in_commit || (state_q == ST_DONE);
  assign commit_cnt_o         = cnt_q;

endmodule

// File: tb/tb_frame_cfg_sequencer.sv
// tb/tb_frame_cfg_sequencer.sv - self-checking bench for frame_cfg_sequencer
module tb_frame_cfg_sequencer;

  logic        clock;
  logic        reset_n;
  logic        vsync_i;
  logic [7:0]  img_mode_i;
  logic [7:0]  load_en;
  logic [7:0]  st_h [3];
  logic [15:0] st_v [3];
  logic [15:0] st_w [3];

  logic [7:0]  act_img_mode_o;
  logic [7:0]  act_h0, act_h1, act_h2;
  logic [15:0] act_v0, act_v1, act_v2;
  logic [15:0] act_w0, act_w1, act_w2;
  logic [2:0]  ch_load_pulse_o;
  logic        commit_done_o, pending_o, busy_o;
  logic [2:0]  err_width_o;
  logic [7:0]  commit_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  frame_cfg_sequencer dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .vsync_i              (vsync_i),
    .img_mode_i           (img_mode_i),
    .base_hsync_ch0_i     (st_h[0]),
    .base_hsync_ch1_i     (st_h[1]),
    .base_hsync_ch2_i     (st_h[2]),
    .base_vsync_ch0_i     (st_v[0]),
    .base_vsync_ch1_i     (st_v[1]),
    .base_vsync_ch2_i     (st_v[2]),
    .width_ch0_i          (st_w[0]),
    .width_ch1_i          (st_w[1]),
    .width_ch2_i          (st_w[2]),
    .chx_load_en_i        (load_en),
    .act_img_mode_o       (act_img_mode_o),
    .act_base_hsync_ch0_o (act_h0),
    .act_base_hsync_ch1_o (act_h1),
    .act_base_hsync_ch2_o (act_h2),
    .act_base_vsync_ch0_o (act_v0),
    .act_base_vsync_ch1_o (act_v1),
    .act_base_vsync_ch2_o (act_v2),
    .act_width_ch0_o      (act_w0),
    .act_width_ch1_o      (act_w1),
    .act_width_ch2_o      (act_w2),
    .ch_load_pulse_o      (ch_load_pulse_o),
    .commit_done_o        (commit_done_o),
    .pending_o            (pending_o),
    .busy_o               (busy_o),
    .err_width_o          (err_width_o),
    .commit_cnt_o         (commit_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be, tracked as "how far into a commit" plus plain arrays
  logic [7:0]  m_mode;
  logic [7:0]  m_h [3];
  logic [15:0] m_v [3];
  logic [15:0] m_w [3];
  logic [2:0]  m_err, m_pulse, m_mask, m_nmask, m_prev;
  logic        m_armed, m_imm, m_pend, m_nimm, m_v0, m_v1;
  int          m_cnt;
  int          m_pos;

  task automatic m_reset();
    m_mode = 0; m_err = 0; m_pulse = 0; m_mask = 0; m_nmask = 0; m_prev = 0;
    m_armed = 0; m_imm = 0; m_pend = 0; m_nimm = 0; m_v0 = 0; m_v1 = 0;
    m_cnt = 0; m_pos = -1;
    for (int i = 0; i < 3; i++) begin
      m_h[i] = 0; m_v[i] = 0; m_w[i] = 0;
    end
  endtask

  task automatic m_step();
    logic [2:0] lm;
    logic       arm, im, rise, old_imm;
    int         n;
    lm      = load_en[2:0];
    arm     = (lm != m_prev) && (lm != 3'b000);
    im      = load_en[7];
    rise    = m_v0 && !m_v1;
    old_imm = m_imm;
    m_pulse = 3'b000;
    if (m_pos < 0) begin
      if (!m_armed) begin
        if (arm) begin
          m_armed = 1; m_mask = lm; m_imm = im;
        end
      end else begin
        if (arm) begin
          m_mask = m_mask | lm; m_imm = m_imm | im;
        end
        if (rise || old_imm) begin
          m_armed = 0; m_pos = 0;
        end
      end
    end else begin
      if (arm) begin
        m_pend = 1; m_nmask = m_nmask | lm; m_nimm = m_nimm | im;
      end
      if (m_pos == 0) begin
        m_mode = img_mode_i;
        m_err  = 3'b000;
      end else if (m_pos <= 3) begin
        n = m_pos - 1;
        if (m_mask[n]) begin
          if (st_w[n] >= 16'd1 && st_w[n] <= 16'd1920) begin
            m_h[n] = st_h[n]; m_v[n] = st_v[n]; m_w[n] = st_w[n];
            m_pulse[n] = 1'b1;
          end else begin
            m_err[n] = 1'b1;
          end
        end
      end else begin
        m_cnt  = (m_cnt + 1) % 256;
        m_mask = 0; m_imm = 0;
        if (m_pend) begin
          m_armed = 1; m_mask = m_nmask; m_imm = m_nimm;
        end
        m_pend = 0; m_nmask = 0; m_nimm = 0;
      end
      m_pos = (m_pos == 4) ? -1 : m_pos + 1;
    end
    m_v1   = m_v0;
    m_v0   = (vsync_i == 1'b1);
    m_prev = lm;
  endtask

  // Advance the model on every active edge, mirroring reset asynchronously
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Compare every output against the model mid-cycle
  always @(negedge clock) begin
    if (reset_n) begin
      chk("mode",    act_img_mode_o, m_mode);
      chk("hsync0",  act_h0, m_h[0]);
      chk("hsync1",  act_h1, m_h[1]);
      chk("hsync2",  act_h2, m_h[2]);
      chk("vsync0",  act_v0, m_v[0]);
      chk("vsync1",  act_v1, m_v[1]);
      chk("vsync2",  act_v2, m_v[2]);
      chk("width0",  act_w0, m_w[0]);
      chk("width1",  act_w1, m_w[1]);
      chk("width2",  act_w2, m_w[2]);
      chk("pulse",   ch_load_pulse_o, m_pulse);
      chk("done",    commit_done_o, (m_pos == 4));
      chk("pending", pending_o, m_armed);
      chk("busy",    busy_o, (m_pos >= 0));
      chk("err",     err_width_o, m_err);
      chk("cnt",     commit_cnt_o, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"}, act_img_mode_o, 0);
    chk({tag, "_h"}, {act_h0, act_h1, act_h2}, 0);
    chk({tag, "_v0"}, act_v0, 0);
    chk({tag, "_v12"}, {act_v1, act_v2}, 0);
    chk({tag, "_w0"}, act_w0, 0);
    chk({tag, "_w12"}, {act_w1, act_w2}, 0);
    chk({tag, "_flags"}, {ch_load_pulse_o, commit_done_o, pending_o, busy_o, err_width_o}, 0);
    chk({tag, "_cnt"}, commit_cnt_o, 0);
  endtask

  initial begin
    // Reset with every input nonzero
    reset_n = 1'b0; vsync_i = 1'b1; img_mode_i = 8'hff; load_en = 8'hff;
    for (int i = 0; i < 3; i++) begin
      st_h[i] = 8'hee; st_v[i] = 16'hdddd; st_w[i] = 16'd100;
    end
    tick(3);
    chk_all_zero("reset");
    load_en = 8'h00; vsync_i = 1'b0; img_mode_i = 8'h00;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    chk("idle_pending", pending_o, 0);
    chk("idle_busy", busy_o, 0);

    // Vsync commit of channel 0 with the documented latency
    st_w[0] = 16'd800; st_h[0] = 8'h10; st_v[0] = 16'h0020; img_mode_i = 8'h03;
    load_en = 8'h01;
    tick(2);
    chk("t1_pending", pending_o, 1);
    vsync_i = 1'b1;
    tick(3);
    chk("t1_mode_k2", act_img_mode_o, 8'h03);
    vsync_i = 1'b0;
    tick(1);
    chk("t1_pulse_k3", ch_load_pulse_o, 3'b001);
    chk("t1_width0", act_w0, 16'd800);
    chk("t1_hsync0", act_h0, 8'h10);
    tick(2);
    chk("t1_done_k5", commit_done_o, 1);
    tick(1);
    chk("t1_cnt", commit_cnt_o, 1);

    // Immediate commit with two illegal widths
    st_w[0] = 16'd640; st_h[0] = 8'h22; st_v[0] = 16'h0033; img_mode_i = 8'h05;
    st_w[1] = 16'd0;   st_h[1] = 8'h44; st_v[1] = 16'h0044;
    st_w[2] = 16'd2000; st_h[2] = 8'h45; st_v[2] = 16'h0045;
    load_en = 8'h87;
    tick(9);
    chk("t2_err", err_width_o, 3'b110);
    chk("t2_width0", act_w0, 16'd640);
    chk("t2_width1", act_w1, 16'd0);
    chk("t2_width2", act_w2, 16'd0);
    chk("t2_hsync1", act_h1, 8'h00);
    chk("t2_mode", act_img_mode_o, 8'h05);
    chk("t2_cnt", commit_cnt_o, 2);

    // Two arms merged while ARMED, committed by one vsync
    load_en = 8'h00;
    st_w[1] = 16'd100;  st_h[1] = 8'h55; st_v[1] = 16'h0066;
    st_w[2] = 16'd1920; st_h[2] = 8'h77; st_v[2] = 16'h0088;
    tick(2);
    load_en = 8'h02;
    tick(2);
    chk("t3_pending_a", pending_o, 1);
    load_en = 8'h04;
    tick(2);
    chk("t3_pending_b", pending_o, 1);
    chk("t3_busy", busy_o, 0);
    vsync_i = 1'b1;
    tick(3);
    vsync_i = 1'b0;
    tick(1);
    chk("t3_pulse_k3", ch_load_pulse_o, 3'b000);
    tick(1);
    chk("t3_pulse_k4", ch_load_pulse_o, 3'b010);
    chk("t3_width1", act_w1, 16'd100);
    tick(1);
    chk("t3_pulse_k5", ch_load_pulse_o, 3'b100);
    chk("t3_width2", act_w2, 16'd1920);
    tick(1);
    chk("t3_cnt", commit_cnt_o, 3);
    chk("t3_err", err_width_o, 3'b000);

    // Arm during LD_CH1 is deferred to the next frame
    load_en = 8'h00;
    tick(2);
    load_en = 8'h01;
    tick(2);
    vsync_i = 1'b1;
    tick(3);
    vsync_i = 1'b0;
    tick(1);
    load_en = 8'h02;
    tick(1);
    chk("t4_busy", busy_o, 1);
    chk("t4_no_pending", pending_o, 0);
    tick(2);
    chk("t4_rearmed", pending_o, 1);
    chk("t4_cnt_a", commit_cnt_o, 4);
    st_w[1] = 16'd300;
    vsync_i = 1'b1;
    tick(3);
    vsync_i = 1'b0;
    tick(4);
    chk("t4_cnt_b", commit_cnt_o, 5);
    chk("t4_width1", act_w1, 16'd300);
    chk("t4_pending_end", pending_o, 0);

    // Counter wrap
    for (int i = 0; i < 250; i++) begin
      load_en = 8'h00;
      tick(1);
      load_en = 8'h81;
      tick(8);
    end
    chk("t5_cnt_255", commit_cnt_o, 255);
    load_en = 8'h00;
    tick(1);
    load_en = 8'h81;
    tick(8);
    chk("t5_cnt_wrap", commit_cnt_o, 0);

    // Asynchronous reset in the middle of LD_CH1
    load_en = 8'h00;
    tick(1);
    load_en = 8'h87;
    tick(4);
    chk("t6_busy_before", busy_o, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick(1);
    load_en = 8'h00;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    chk("t6_pending", pending_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_mode", act_img_mode_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
